// File: rtl/player_input_pkg.sv
// Shared constants for player_input: PS/2 scan codes, bit positions and the player vector type.
// No logic of its own.
// The helper function is a pure bit remap used by the top module.
package input_pkg;

    typedef logic [9:0] player_t;

    // Player vector bit positions: {service, coin, start, b3, b2, b1, right, left, down, up}
    localparam int P_UP      = 0;
    localparam int P_DOWN    = 1;
    localparam int P_LEFT    = 2;
    localparam int P_RIGHT   = 3;
    localparam int P_B1      = 4;
    localparam int P_B2      = 5;
    localparam int P_B3      = 6;
    localparam int P_START   = 7;
    localparam int P_COIN    = 8;
    localparam int P_SERVICE = 9;

    // MiSTer joystick word bit positions
    localparam int J_RIGHT   = 0;
    localparam int J_LEFT    = 1;
    localparam int J_DOWN    = 2;
    localparam int J_UP      = 3;
    localparam int J_B1      = 4;
    localparam int J_B2      = 5;
    localparam int J_B3      = 6;
    localparam int J_START   = 7;
    localparam int J_COIN    = 8;
    localparam int J_PAUSE   = 9;
    localparam int J_SERVICE = 10;

    // Player 1 scan codes
    localparam logic [7:0] SC_UP       = 8'h75;
    localparam logic [7:0] SC_DOWN     = 8'h72;
    localparam logic [7:0] SC_LEFT     = 8'h6B;
    localparam logic [7:0] SC_RIGHT    = 8'h74;
    localparam logic [7:0] SC_B1       = 8'h14;
    localparam logic [7:0] SC_B2       = 8'h11;
    localparam logic [7:0] SC_B3       = 8'h29;
    localparam logic [7:0] SC_START    = 8'h16;
    localparam logic [7:0] SC_COIN     = 8'h2E;
    localparam logic [7:0] SC_SERVICE  = 8'h46;

    // Player 2 scan codes
    localparam logic [7:0] SC2_UP      = 8'h2D;
    localparam logic [7:0] SC2_DOWN    = 8'h2B;
    localparam logic [7:0] SC2_LEFT    = 8'h23;
    localparam logic [7:0] SC2_RIGHT   = 8'h34;
    localparam logic [7:0] SC2_B1      = 8'h1C;
    localparam logic [7:0] SC2_B2      = 8'h1B;
    localparam logic [7:0] SC2_B3      = 8'h15;
    localparam logic [7:0] SC2_START   = 8'h1E;
    localparam logic [7:0] SC2_COIN    = 8'h36;
    localparam logic [7:0] SC2_SERVICE = 8'h45;

    // Shared pause key
    localparam logic [7:0] SC_PAUSE    = 8'h4D;

    // Reorder a joystick word into player vector order (pause bit is handled separately)
    function automatic player_t joy_to_player(input logic [10:0] j);
        player_t p;
        p[P_UP]      = j[J_UP];
        p[P_DOWN]    = j[J_DOWN];
        p[P_LEFT]    = j[J_LEFT];
        p[P_RIGHT]   = j[J_RIGHT];
        p[P_B1]      = j[J_B1];
        p[P_B2]      = j[J_B2];
        p[P_B3]      = j[J_B3];
        p[P_START]   = j[J_START];
        p[P_COIN]    = j[J_COIN];
        p[P_SERVICE] = j[J_SERVICE];
        return p;
    endfunction

endpackage

// File: rtl/player_input_coin_stretcher.sv
// Coin pulse stretcher: holds coin high for at least COIN_FRAMES vblank rising edges.
// Combinational from coin_in to coin_out; counter updates one clock after the coin edge.
// No backpressure; a new coin edge always reloads the full count.
module coin_stretcher #(
    parameter int COIN_FRAMES = 3,
    parameter int CNT_W       = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic coin_in,
    input  logic vblank_edge,
    output logic coin_out
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_coin_prev;

    // Load on a coin rising edge (wins over a same-cycle vblank edge), else count vblank edges down
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_coin_prev <= 1'b0;
        end else begin
            r_coin_prev <= coin_in;
            if (coin_in && !r_coin_prev) begin
                r_cnt <= CNT_W'(COIN_FRAMES);
            end else if (vblank_edge && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign coin_out = coin_in | (r_cnt != '0);

endmodule

// File: rtl/player_input.sv
// Merges PS/2 held-key state with MiSTer joysticks into registered player vectors plus a pause toggle.
// Joystick -> output 1 clock; PS/2 event -> key register 1 clock, output 2 clocks.
// No backpressure; every PS/2 event is consumed on the clock it is seen.
module player_input
    import input_pkg::*;
#(
    parameter int COIN_FRAMES = 3,
    parameter int CNT_W       = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [10:0] joystick_0,
    input  logic [10:0] joystick_1,
    input  logic        vblank,
    output logic [9:0]  player1,
    output logic [9:0]  player2,
    output logic        pause
);

    player_t r_key1;
    player_t r_key2;
    logic    r_key_p;
    logic    r_toggle_prev;
    logic    r_armed;
    logic    r_vblank_prev;
    logic    r_pause_prev;
    logic    r_pause;
    player_t r_player1;
    player_t r_player2;

    logic    w_key_event;
    logic    w_vblank_edge;
    logic    w_pause_raw;
    logic    w_coin1;
    logic    w_coin2;
    logic    w_unused_ext;
    player_t w_raw1;
    player_t w_raw2;
    player_t w_out1;
    player_t w_out2;

    // The extended-code flag carries no meaning for this key map
    assign w_unused_ext = ps2_key[8];

    // The first edge after reset only captures the toggle level, so a stale toggle is not an event
    assign w_key_event = r_armed && (ps2_key[10] != r_toggle_prev);

    // Track the toggle bit and latch the pressed level into the key selected by the scan code
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_key1        <= '0;
            r_key2        <= '0;
            r_key_p       <= 1'b0;
            r_toggle_prev <= 1'b0;
            r_armed       <= 1'b0;
        end else begin
            r_armed       <= 1'b1;
            r_toggle_prev <= ps2_key[10];
            if (w_key_event) begin
                case (ps2_key[7:0])
                    SC_UP:       r_key1[P_UP]      <= ps2_key[9];
                    SC_DOWN:     r_key1[P_DOWN]    <= ps2_key[9];
                    SC_LEFT:     r_key1[P_LEFT]    <= ps2_key[9];
                    SC_RIGHT:    r_key1[P_RIGHT]   <= ps2_key[9];
                    SC_B1:       r_key1[P_B1]      <= ps2_key[9];
                    SC_B2:       r_key1[P_B2]      <= ps2_key[9];
                    SC_B3:       r_key1[P_B3]      <= ps2_key[9];
                    SC_START:    r_key1[P_START]   <= ps2_key[9];
                    SC_COIN:     r_key1[P_COIN]    <= ps2_key[9];
                    SC_SERVICE:  r_key1[P_SERVICE] <= ps2_key[9];
                    SC2_UP:      r_key2[P_UP]      <= ps2_key[9];
                    SC2_DOWN:    r_key2[P_DOWN]    <= ps2_key[9];
                    SC2_LEFT:    r_key2[P_LEFT]    <= ps2_key[9];
                    SC2_RIGHT:   r_key2[P_RIGHT]   <= ps2_key[9];
                    SC2_B1:      r_key2[P_B1]      <= ps2_key[9];
                    SC2_B2:      r_key2[P_B2]      <= ps2_key[9];
                    SC2_B3:      r_key2[P_B3]      <= ps2_key[9];
                    SC2_START:   r_key2[P_START]   <= ps2_key[9];
                    SC2_COIN:    r_key2[P_COIN]    <= ps2_key[9];
                    SC2_SERVICE: r_key2[P_SERVICE] <= ps2_key[9];
                    SC_PAUSE:    r_key_p           <= ps2_key[9];
                    default:     ;
                endcase
            end
        end
    end

    assign w_raw1 = r_key1 | joy_to_player(joystick_0);
    assign w_raw2 = r_key2 | joy_to_player(joystick_1);

    // vblank_prev resets high so a vblank already high at reset release is not an edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vblank_prev <= 1'b1;
        end else begin
            r_vblank_prev <= vblank;
        end
    end

    assign w_vblank_edge = vblank && !r_vblank_prev;

    coin_stretcher #(
        .COIN_FRAMES (COIN_FRAMES),
        .CNT_W       (CNT_W)
    ) u_coin1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .coin_in     (w_raw1[P_COIN]),
        .vblank_edge (w_vblank_edge),
        .coin_out    (w_coin1)
    );

    coin_stretcher #(
        .COIN_FRAMES (COIN_FRAMES),
        .CNT_W       (CNT_W)
    ) u_coin2 (
        .clock       (clock),
        .reset_n     (reset_n),
        .coin_in     (w_raw2[P_COIN]),
        .vblank_edge (w_vblank_edge),
        .coin_out    (w_coin2)
    );

    // Substitute the stretched coin into each raw vector
    always_comb begin
        w_out1         = w_raw1;
        w_out2         = w_raw2;
        w_out1[P_COIN] = w_coin1;
        w_out2[P_COIN] = w_coin2;
    end

    assign w_pause_raw = r_key_p | joystick_0[J_PAUSE] | joystick_1[J_PAUSE];

    // Flip pause once per rising edge of any pause source; register the player vectors
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pause_prev <= 1'b0;
            r_pause      <= 1'b0;
            r_player1    <= '0;
            r_player2    <= '0;
        end else begin
            r_pause_prev <= w_pause_raw;
            if (w_pause_raw && !r_pause_prev) begin
                r_pause <= !r_pause;
            end
            r_player1 <= w_out1;
            r_player2 <= w_out2;
        end
    end

    assign player1 = r_player1;
    assign player2 = r_player2;
    assign pause   = r_pause;

endmodule

// File: tb/tb_player_input.sv
// Bench for player_input: directed scenarios with literal expectations plus a randomized run.
// A key-table model (held state indexed by scan code) predicts every output each cycle.
module tb_player_input;

    localparam int COIN_FRAMES = 3;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b0;
    logic [10:0] ps2_key    = '0;
    logic [10:0] joystick_0 = '0;
    logic [10:0] joystick_1 = '0;
    logic        vblank     = 1'b1;
    logic [9:0]  player1;
    logic [9:0]  player2;
    logic        pause;

    player_input #(.COIN_FRAMES(COIN_FRAMES), .CNT_W(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .vblank     (vblank),
        .player1    (player1),
        .player2    (player2),
        .pause      (pause)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] P1_CODES [10] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h16, 8'h2E, 8'h46};
    logic [7:0] P2_CODES [10] = '{8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h36, 8'h45};
    int         JBIT     [10] = '{3, 2, 1, 0, 4, 5, 6, 7, 8, 10};

    bit         held [256];
    int         m_cnt [2];
    bit         m_coin_prev [2];
    bit         m_armed, m_tog, m_vb_prev, m_praw_prev, m_pause;
    logic [9:0] exp_p1 = '0;
    logic [9:0] exp_p2 = '0;
    logic       exp_pause = 1'b0;
    logic [9:0] m_r [2];
    bit         m_vb_edge, m_praw;

    function automatic logic [9:0] m_raw(input bit p2, input logic [10:0] j);
        logic [9:0] r;
        for (int i = 0; i < 10; i++)
            r[i] = (p2 ? held[P2_CODES[i]] : held[P1_CODES[i]]) | j[JBIT[i]];
        return r;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            foreach (held[i]) held[i] = 1'b0;
            m_cnt[0] = 0; m_cnt[1] = 0;
            m_coin_prev[0] = 1'b0; m_coin_prev[1] = 1'b0;
            m_armed = 1'b0; m_tog = 1'b0; m_vb_prev = 1'b1;
            m_praw_prev = 1'b0; m_pause = 1'b0;
            exp_p1 = '0; exp_p2 = '0; exp_pause = 1'b0;
        end else begin
            m_r[0] = m_raw(1'b0, joystick_0);
            m_r[1] = m_raw(1'b1, joystick_1);
            m_vb_edge = vblank && !m_vb_prev;
            for (int p = 0; p < 2; p++) begin
                bit rc;
                rc = m_r[p][8];
                m_r[p][8] = rc || (m_cnt[p] != 0);
                if (rc && !m_coin_prev[p]) m_cnt[p] = COIN_FRAMES;
                else if (m_vb_edge && m_cnt[p] > 0) m_cnt[p] = m_cnt[p] - 1;
                m_coin_prev[p] = rc;
            end
            exp_p1 = m_r[0];
            exp_p2 = m_r[1];
            m_praw = held[8'h4D] | joystick_0[9] | joystick_1[9];
            if (m_praw && !m_praw_prev) m_pause = !m_pause;
            m_praw_prev = m_praw;
            exp_pause = m_pause;
            m_vb_prev = vblank;
            if (!m_armed) begin
                m_armed = 1'b1;
            end else if (ps2_key[10] != m_tog) begin
                held[ps2_key[7:0]] = ps2_key[9];
            end
            m_tog = ps2_key[10];
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (chk_en) begin
            chk("model player1", 32'(player1), 32'(exp_p1));
            chk("model player2", 32'(player2), 32'(exp_p2));
            chk("model pause",   32'(pause),   32'(exp_pause));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic key_ev(input logic [7:0] code, input logic pr);
        ps2_key = {~ps2_key[10], pr, 1'b0, code};
    endtask

    task automatic vb_pulse();
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
    endtask

    task automatic coin1_pulse();
        joystick_0[8] = 1'b1;
        tick();
        joystick_0[8] = 1'b0;
    endtask

    int         vb_timer;
    int         sel;
    logic [7:0] code;
    int         bitn;

    initial begin
        // Reset state, with a pressed-looking event pending across release
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h16};
        tick(2);
        chk("reset player1", 32'(player1), 32'h0);
        chk("reset player2", 32'(player2), 32'h0);
        chk("reset pause",   32'(pause),   32'h0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick(20);
        chk("stale toggle start", 32'(player1[7]), 32'h0);
        key_ev(8'h16, 1'b1);
        tick(2);
        chk("start after real event", 32'(player1[7]), 32'h1);
        key_ev(8'h16, 1'b0);
        tick(2);

        // Key press/release latency
        key_ev(8'h75, 1'b1);
        tick();
        chk("up press +1", 32'(player1[0]), 32'h0);
        tick();
        chk("up press +2", 32'(player1[0]), 32'h1);
        chk("p2 during p1 key", 32'(player2), 32'h0);
        key_ev(8'h75, 1'b0);
        tick();
        chk("up release +1", 32'(player1[0]), 32'h1);
        tick();
        chk("up release +2", 32'(player1[0]), 32'h0);

        // Coin stretch with vblank held high across reset release
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(2);
        coin1_pulse();
        chk("coin next clock", 32'(player1[8]), 32'h1);
        tick(3);
        chk("coin held vblank", 32'(player1[8]), 32'h1);
        vb_pulse();
        vb_pulse();
        chk("coin after 2 edges", 32'(player1[8]), 32'h1);
        vb_pulse();
        chk("coin at 3rd edge", 32'(player1[8]), 32'h1);
        tick();
        chk("coin expired", 32'(player1[8]), 32'h0);

        // Retrigger during an active stretch
        coin1_pulse();
        vb_pulse();
        vb_pulse();
        coin1_pulse();
        vb_pulse();
        vb_pulse();
        tick();
        chk("coin retrigger", 32'(player1[8]), 32'h1);
        vb_pulse();
        tick();
        chk("coin retrigger end", 32'(player1[8]), 32'h0);

        // Coin edge coincident with a vblank edge during a stretch
        coin1_pulse();
        vb_pulse();
        vblank = 1'b0;
        tick();
        joystick_0[8] = 1'b1;
        vblank = 1'b1;
        tick();
        joystick_0[8] = 1'b0;
        vb_pulse();
        vb_pulse();
        tick();
        chk("coin+vblank load wins", 32'(player1[8]), 32'h1);
        vb_pulse();
        tick();
        chk("coin+vblank end", 32'(player1[8]), 32'h0);

        // Pause toggle
        chk("pause initial", 32'(pause), 32'h0);
        joystick_1[9] = 1'b1;
        tick();
        chk("pause flip joy1", 32'(pause), 32'h1);
        tick(49);
        chk("pause held once", 32'(pause), 32'h1);
        joystick_1[9] = 1'b0;
        tick();
        key_ev(8'h4D, 1'b1);
        tick();
        chk("pause key +1", 32'(pause), 32'h1);
        tick();
        chk("pause key +2", 32'(pause), 32'h0);
        key_ev(8'h4D, 1'b0);
        tick(2);
        joystick_0[9] = 1'b1;
        key_ev(8'h4D, 1'b1);
        tick();
        chk("pause both flip", 32'(pause), 32'h1);
        tick(3);
        chk("pause both single", 32'(pause), 32'h1);
        joystick_0[9] = 1'b0;
        key_ev(8'h4D, 1'b0);
        tick(3);

        // Async reset mid-stretch with a key held
        key_ev(8'h75, 1'b1);
        joystick_1[8] = 1'b1;
        tick();
        joystick_1[8] = 1'b0;
        tick(2);
        chk("pre-reset p1 up", 32'(player1[0]), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async player1", 32'(player1), 32'h0);
        chk("async player2", 32'(player2), 32'h0);
        chk("async pause",   32'(pause),   32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        joystick_1[7] = 1'b1;
        tick();
        chk("post-reset p2 start", 32'(player2), 32'h080);
        chk("post-reset key lost", 32'(player1), 32'h0);
        joystick_1[7] = 1'b0;
        tick(2);

        // Randomized run
        vb_timer = 4;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                sel = $urandom_range(0, 24);
                if (sel < 10)       code = P1_CODES[sel];
                else if (sel < 20)  code = P2_CODES[sel - 10];
                else if (sel < 22)  code = 8'h4D;
                else                code = 8'($urandom_range(0, 255));
                key_ev(code, 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 5) == 0) begin
                bitn = $urandom_range(0, 10);
                joystick_0[bitn] = ~joystick_0[bitn];
            end
            if ($urandom_range(0, 5) == 0) begin
                bitn = $urandom_range(0, 10);
                joystick_1[bitn] = ~joystick_1[bitn];
            end
            vb_timer--;
            if (vb_timer <= 0) begin
                vblank   = ~vblank;
                vb_timer = $urandom_range(1, 8);
            end
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 1'b0;
                tick(2);
                reset_n = 1'b1;
            end
            tick();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
